alu_exec_unit: RTL

//   Execute-stage ALU consuming the 4-bit alu_ctrl code produced by the ALU control decoder.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_shift_seq.sv | 60 ++++++
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the execute-stage ALU and the ALU control decoder:
//   the 4-bit alu_ctrl code table and the execute-unit FSM state encoding.
//   Both ends import this package so the code table exists in one place only.
// -----------------------------------------------------------------------------
package alu_pkg;

  // alu_ctrl code table
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b1111;

  // Execute-unit FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // Shifts are the only multi-cycle operations.
  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_shift_seq.sv
// -----------------------------------------------------------------------------
// alu_shift_seq
//   Iterative 1-bit-per-cycle logical shifter: a shift register plus a
//   down-counter. i_start loads the operand and shift amount; afterwards the
//   register shifts once per cycle while the counter is non-zero.
//
//   Ports
//     clk          in   rising-edge clock
//     rst          in   synchronous active-high reset
//     i_start      in   load i_data / i_shamt / i_dir_right this cycle
//     i_dir_right  in   0: shift left (sll), 1: logical shift right (srl)
//     i_data       in   value to be shifted
//     i_shamt      in   number of single-bit shifts to perform
//     o_last       out  the shift happening this cycle is the final one
//     o_shifted    out  register value after this cycle's shift
// -----------------------------------------------------------------------------
module alu_shift_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_dir_right,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_last,
  output logic [DATA_W-1:0]  o_shifted
);

  logic [DATA_W-1:0]  r_sreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_dir_right;
  logic [DATA_W-1:0]  w_shifted;

  // Both directions fill with zeros (srl is logical, not arithmetic).
  assign w_shifted = r_dir_right ? (r_sreg >> 1) : (r_sreg << 1);

  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
    end else if (i_start) begin
      r_sreg      <= i_data;
      r_cnt       <= i_shamt;
      r_dir_right <= i_dir_right;
    end else if (r_cnt != '0) begin
      r_sreg <= w_shifted;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

  // The caller captures o_shifted on the cycle the counter reads 1.
  assign o_last    = (r_cnt == SHAMT_W'(1));
  assign o_shifted = w_shifted;

endmodule : alu_shift_seq

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU between the ID/EX and EX/MEM registers. Single-cycle
//   ops (add/sub/and/or/xor/nor/slt) register their result on the accept
//   edge; sll/srl run one bit per cycle in alu_shift_seq while busy stalls
//   the upstream stage. valid/ready handshakes on both sides.
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset
//     in_valid   in   operation presented by ID/EX
//     in_ready   out  unit accepts an operation this cycle
//     alu_ctrl   in   4-bit operation code (alu_pkg table, unknown -> add)
//     src_a      in   operand A (rs)
//     src_b      in   operand B (rt/imm); the shifted value for sll/srl
//     shamt      in   shift amount, used only for sll/srl
//     out_valid  out  result/zero valid
//     out_ready  in   EX/MEM consumes result
//     result     out  registered result
//     zero       out  result == 0, registered with result
//     busy       out  high while an iterative shift is in progress
//
//   SHAMT_W must equal clog2(DATA_W) so every bit position is reachable.
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctrl,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               busy
);

  alu_state_e         r_state;
  logic [DATA_W-1:0]  r_result;
  logic               r_zero;
  logic               r_out_valid;
  logic               r_busy;

  logic               w_accept;
  logic               w_is_shift;
  logic [DATA_W-1:0]  w_alu_result;
  logic               w_alu_zero;
  logic               w_seq_last;
  logic [DATA_W-1:0]  w_seq_shifted;

  // ---------------------------------------------------------------------------
  // Handshake: a finished result can be replaced in the same cycle it is
  // consumed, which gives one op per cycle while out_ready stays high.
  // ---------------------------------------------------------------------------
  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = is_shift_op(alu_ctrl);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath. Shift codes pass src_b through: that is the
  // complete answer for a zero shift amount.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_alu_result = src_a + src_b;
    case (alu_ctrl)
      ALU_ADD: w_alu_result = src_a + src_b;
      ALU_SUB: w_alu_result = src_a - src_b;
      ALU_AND: w_alu_result = src_a & src_b;
      ALU_OR:  w_alu_result = src_a | src_b;
      ALU_XOR: w_alu_result = src_a ^ src_b;
      ALU_NOR: w_alu_result = ~(src_a | src_b);
      ALU_SLT: w_alu_result = ($signed(src_a) < $signed(src_b)) ?
                              DATA_W'(1) : '0;
      ALU_SLL,
      ALU_SRL: w_alu_result = src_b;
      default: w_alu_result = src_a + src_b;
    endcase
  end

  assign w_alu_zero = (w_alu_result == '0);

  // ---------------------------------------------------------------------------
  // Iterative shifter. Loading on any shift accept is harmless for shamt==0:
  // the counter loads zero and the sequencer stays idle.
  // ---------------------------------------------------------------------------
  alu_shift_seq #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shift_seq (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_accept && w_is_shift),
    .i_dir_right (alu_ctrl == ALU_SRL),
    .i_data      (src_b),
    .i_shamt     (shamt),
    .o_last      (w_seq_last),
    .o_shifted   (w_seq_shifted)
  );

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_is_shift && (shamt != '0)) begin
              r_state     <= ST_SHIFT;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_state     <= ST_DONE;
              r_result    <= w_alu_result;
              r_zero      <= w_alu_zero;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b0;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
          // DONE with out_ready low: result, zero and out_valid hold.
        end

        ST_SHIFT: begin
          // zero is taken from the final shifted value only.
          if (w_seq_last) begin
            r_state     <= ST_DONE;
            r_result    <= w_seq_shifted;
            r_zero      <= (w_seq_shifted == '0);
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign busy      = r_busy;

endmodule : alu_exec_unit
